// File: rtl/servant_mtimer.sv
// Wishbone-mapped machine timer: prescaled mtime, mtimecmp, wrap-safe compare and timer IRQ.
// Optional wakeup pulse generation is enabled by defining SERVANT_MTIMER_WAKEUP_EN.
module servant_mtimer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_irq,
  input  logic        i_sleep_req,
  output logic        o_wakeup_req
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  localparam logic [1:0] AdrMtime = 2'd0;
  localparam logic [1:0] AdrMtimecmp = 2'd1;
  localparam logic [1:0] AdrCtrl = 2'd2;

  if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
    $error("servant_mtimer: WIDTH must be within 8..32");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("servant_mtimer: PRESCALE must be within 1..65535");
  end

  logic [WIDTH-1:0] r_mtime;
  logic [WIDTH-1:0] r_mtimecmp;
  logic [1:0]       r_ctrl;
  logic [CntW-1:0]  r_cnt;
  logic             r_ack;
  logic [31:0]      r_rdat;
  logic             r_irq;

  logic             w_access;
  logic             w_wr_mtime;
  logic             w_wr_mtimecmp;
  logic             w_wr_ctrl;
  logic             w_rd;
  logic             w_en;
  logic             w_ie;
  logic             w_tick;
  logic [WIDTH-1:0] w_diff;
  logic             w_hit;
  logic [31:0]      w_rdat;

  // An access is accepted only while no ack is outstanding, so acks never come back to back.
  assign w_access      = i_wb_cyc & ~r_ack;
  assign w_wr_mtime    = w_access & i_wb_we & (i_wb_adr == AdrMtime);
  assign w_wr_mtimecmp = w_access & i_wb_we & (i_wb_adr == AdrMtimecmp);
  assign w_wr_ctrl     = w_access & i_wb_we & (i_wb_adr == AdrCtrl);
  assign w_rd          = w_access & ~i_wb_we;

  assign w_en   = r_ctrl[0];
  assign w_ie   = r_ctrl[1];
  assign w_tick = w_en & (r_cnt == CntMax);

  // Wrap-safe compare: mtime is at or past mtimecmp when the difference is non-negative.
  assign w_diff = r_mtime - r_mtimecmp;
  assign w_hit  = ~w_diff[WIDTH-1];

  always_comb begin
    w_rdat = 32'd0;
    case (i_wb_adr)
      AdrMtime:    w_rdat = 32'(r_mtime);
      AdrMtimecmp: w_rdat = 32'(r_mtimecmp);
      AdrCtrl:     w_rdat = {30'd0, r_ctrl};
      default:     w_rdat = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack  <= 1'b0;
      r_rdat <= 32'd0;
    end else begin
      r_ack  <= w_access;
      r_rdat <= w_rd ? w_rdat : 32'd0;
    end
  end

  // A software write to mtime overrides any tick in the same cycle and restarts the prescaler.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime <= '0;
      r_cnt   <= '0;
    end else if (w_wr_mtime) begin
      r_mtime <= i_wb_dat[WIDTH-1:0];
      r_cnt   <= '0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + WIDTH'(1);
      r_cnt   <= '0;
    end else if (w_en) begin
      r_cnt   <= r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtimecmp <= '0;
      r_ctrl     <= 2'b00;
    end else begin
      if (w_wr_mtimecmp) r_mtimecmp <= i_wb_dat[WIDTH-1:0];
      if (w_wr_ctrl)     r_ctrl     <= i_wb_dat[1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_irq <= 1'b0;
    else       r_irq <= w_ie & w_hit;
  end

  assign o_wb_ack = r_ack;
  assign o_wb_dat = r_rdat;
  assign o_irq    = r_irq;

`ifdef SERVANT_MTIMER_WAKEUP_EN
  logic r_irq_q;
  logic r_sleep_q;
  logic r_wakeup;
  logic w_wakeup;

  // Pulse on an IRQ rising edge during sleep, or on sleep entry with the IRQ already high.
  assign w_wakeup = i_sleep_req & r_irq & (~r_irq_q | ~r_sleep_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq_q   <= 1'b0;
      r_sleep_q <= 1'b0;
      r_wakeup  <= 1'b0;
    end else begin
      r_irq_q   <= r_irq;
      r_sleep_q <= i_sleep_req;
      r_wakeup  <= w_wakeup;
    end
  end

  assign o_wakeup_req = r_wakeup;
`else
  logic w_unused_sleep;
  assign w_unused_sleep = i_sleep_req;
  assign o_wakeup_req   = 1'b0;
`endif

endmodule

// File: tb/tb_servant_mtimer.sv
// Directed bench for servant_mtimer: three instances (32b/P1, 32b/P4, 8b/P1) on one shared bus.
// Expected values are hand-computed from write edges; wakeup checks follow SERVANT_MTIMER_WAKEUP_EN.
module tb_servant_mtimer;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic        sleep;

  logic [31:0] rdat0, rdat1, rdat2;
  logic        ack0, ack1, ack2;
  logic        irq0, irq1, irq2;
  logic        wake0, wake1, wake2;

  logic [31:0] rd0, rd1, rd2;
  logic [31:0] sav0, sav1;
  int          n_vec;
  int          n_err;

  servant_mtimer #(.WIDTH(32), .PRESCALE(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(wdat),
    .o_wb_dat(rdat0), .o_wb_ack(ack0), .o_irq(irq0), .i_sleep_req(sleep),
    .o_wakeup_req(wake0)
  );

  servant_mtimer #(.WIDTH(32), .PRESCALE(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(wdat),
    .o_wb_dat(rdat1), .o_wb_ack(ack1), .o_irq(irq1), .i_sleep_req(sleep),
    .o_wakeup_req(wake1)
  );

  servant_mtimer #(.WIDTH(8), .PRESCALE(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(wdat),
    .o_wb_dat(rdat2), .o_wb_ack(ack2), .o_irq(irq2), .i_sleep_req(sleep),
    .o_wakeup_req(wake2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    cyc  = 1'b0;
    we   = 1'b0;
    adr  = 2'd0;
    wdat = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Access lands on the posedge after the first negedge; returns one cycle after that edge.
  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    @(negedge clk);
    check_eq("ack", {29'd0, ack2, ack1, ack0}, 32'h7);
    rd0 = rdat0;
    rd1 = rdat1;
    rd2 = rdat2;
    cyc = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    check_eq("ack_single", {29'd0, ack2, ack1, ack0}, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wb_xfer(1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    wb_xfer(1'b0, a, 32'd0);
  endtask

  initial begin
    int pulses;
    int maxrun;
    int run;
    n_vec = 0;
    n_err = 0;
    sleep = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_outs", {25'd0, wake2, wake1, wake0, irq2, irq1, irq0, ack0}, 32'h0);
    check_eq("rst_dat", rdat0 | rdat1 | rdat2, 32'h0);
    rd(2'd0);
    check_eq("rst_mtime", rd0, 32'h0);
    rd(2'd1);
    check_eq("rst_cmp", rd0, 32'h0);
    rd(2'd2);
    check_eq("rst_ctrl", rd0, 32'h0);

    // Free run, PRESCALE=1: ~10 cycles after enabling
    do_reset();
    wr(2'd2, 32'h3);
    repeat (8) @(negedge clk);
    rd(2'd0);
    check_eq("run_p1", 32'((rd0 >= 32'd9) && (rd0 <= 32'd11)), 32'h1);
    check_eq("run_p4", rd1, 32'd2);
    check_eq("run_w8", rd2, 32'd10);

    // PRESCALE=4 rate and EN=0 freeze
    do_reset();
    wr(2'd2, 32'h1);
    rd(2'd0);
    sav0 = rd0;
    sav1 = rd1;
    repeat (17) @(negedge clk);
    rd(2'd0);
    check_eq("p4_rate20", rd1 - sav1, 32'd5);
    check_eq("p1_rate20", rd0 - sav0, 32'd20);
    sav1 = rd1;
    repeat (1) @(negedge clk);
    rd(2'd0);
    check_eq("p4_rate4", rd1 - sav1, 32'd1);
    wr(2'd2, 32'h0);
    rd(2'd0);
    sav0 = rd0;
    sav1 = rd1;
    repeat (17) @(negedge clk);
    rd(2'd0);
    check_eq("freeze_p4", rd1, sav1);
    check_eq("freeze_p1", rd0, sav0);

    // Compare at 50, then clear by moving mtimecmp ahead
    do_reset();
    wr(2'd1, 32'd50);
    wr(2'd2, 32'h3);
    repeat (49) @(negedge clk);
    check_eq("irq_before50", {31'd0, irq0}, 32'h0);
    @(negedge clk);
    check_eq("irq_at50", {31'd0, irq0}, 32'h1);
    wr(2'd1, 32'd100);
    check_eq("irq_clear", {31'd0, irq0}, 32'h0);

    // WIDTH=8 wrap: 0xFE .. 0x02
    do_reset();
    wr(2'd0, 32'hFE);
    wr(2'd1, 32'h02);
    wr(2'd2, 32'h3);
    check_eq("w8_fe", {31'd0, irq2}, 32'h0);
    @(negedge clk);
    check_eq("w8_ff", {31'd0, irq2}, 32'h0);
    @(negedge clk);
    check_eq("w8_00", {31'd0, irq2}, 32'h0);
    @(negedge clk);
    check_eq("w8_01", {31'd0, irq2}, 32'h0);
    @(negedge clk);
    check_eq("w8_02", {31'd0, irq2}, 32'h1);
    @(negedge clk);
    check_eq("w8_03", {31'd0, irq2}, 32'h1);

    // mtime write on a tick cycle wins; three ticks follow before EN drops
    do_reset();
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h0000_1234);
    wr(2'd2, 32'h0);
    rd(2'd0);
    check_eq("wr_tick_p1", rd0, 32'h0000_1237);
    check_eq("wr_tick_p4", rd1, 32'h0000_1234);
    check_eq("wr_tick_w8", rd2, 32'h0000_0037);

    // Register masking and zero extension
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    check_eq("ctrl_mask", rd0, 32'h3);
    rd(2'd3);
    check_eq("rsvd_zero", rd0 | rd1 | rd2, 32'h0);
    wr(2'd1, 32'hA5A5_5A5A);
    rd(2'd1);
    check_eq("cmp_rd32", rd0, 32'hA5A5_5A5A);
    check_eq("cmp_rd8", rd2, 32'h0000_005A);

    // Reset in the middle of an access
    wr(2'd1, 32'h0);
    check_eq("irq_pre_rst", {31'd0, irq0}, 32'h1);
    @(negedge clk);
    cyc  = 1'b1;
    we   = 1'b1;
    adr  = 2'd0;
    wdat = 32'hDEAD_BEEF;
    rst  = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ctl", {26'd0, wake2, wake1, wake0, ack2, ack1, ack0}, 32'h0);
    check_eq("rst_mid_irq", {29'd0, irq2, irq1, irq0}, 32'h0);
    check_eq("rst_mid_dat", rdat0 | rdat1 | rdat2, 32'h0);
    rst = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
    rd(2'd0);
    check_eq("rst_mid_mtime", rd0, 32'h0);

    // Wakeup pulses while sleeping
    do_reset();
    sleep = 1'b1;
    wr(2'd1, 32'd5);
    wr(2'd2, 32'h3);
    pulses = 0;
    maxrun = 0;
    run    = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wake0) begin
        run++;
        if (run == 1) pulses++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check_eq("irq_sleep", {31'd0, irq0}, 32'h1);
`ifdef SERVANT_MTIMER_WAKEUP_EN
    check_eq("wake_pulses", 32'(pulses), 32'd1);
    check_eq("wake_width", 32'(maxrun), 32'd1);
`else
    check_eq("wake_pulses", 32'(pulses), 32'd0);
    check_eq("wake_width", 32'(maxrun), 32'd0);
`endif
    sleep = 1'b0;
    repeat (2) @(negedge clk);
    sleep  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wake0) pulses++;
    end
`ifdef SERVANT_MTIMER_WAKEUP_EN
    check_eq("wake_resleep", 32'(pulses), 32'd1);
`else
    check_eq("wake_resleep", 32'(pulses), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
